max_min_stream: RTL and testbench
=================================

Name: max_min_stream

Overview:
- Sequential streaming counterpart to the combinational 3-input maximum unit.
- Accepts a frame of WIDTH-bit words, one per clock, over a valid/ready input handshake.
- At frame end it reports maximum, minimum, position of the maximum and word count over a valid/ready output handshake.
- Sits between a sample source and the comparison/statistics consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, data word width; instantiated with `WIDTH from define.v.
- CNT_W, 8, width of the word counter and index outputs.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  data word.
- in_last  input  1  marks final word of frame.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts result.
- out_max  output  WIDTH  frame maximum.
- out_min  output  WIDTH  frame minimum.
- out_max_idx  output  CNT_W  0-based index of the first occurrence of the maximum.
- out_count  output  CNT_W  number of words in the frame (saturating).
- out_ovf  output  1  frame length exceeded 2^CNT_W-1.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high, 1 after release; out_valid=0; out_max, out_min, out_max_idx, out_count=0; out_ovf=0.
- Beat accepted when in_valid && in_ready at a rising clk edge. Output transfer occurs when out_valid && out_ready.
- IDLE (in_ready=1, out_valid=0): on an accepted beat, load max=min=in_data, max_idx=0, count=1, ovf=0.
  - Then go to ACC, or to DONE if in_last=1.
- ACC (in_ready=1): on each accepted beat:
  - If data > max, then max=data and max_idx=count (count before increment).
  - If data < min, then min=data.
  - count increments; on a beat accepted at count = 2^CNT_W-1, count stays at 2^CNT_W-1 and ovf sets sticky. max_idx saturates the same way.
  - Ties never update max_idx.
  - in_last=1 on the beat goes to DONE. in_valid=0 holds state, with no timeout.
- DONE (in_ready=0, out_valid=1): outputs stable and held until out_ready=1; the transfer returns to IDLE.
  - out_valid deasserts the cycle after the transfer.
  - No new input is accepted in the transfer cycle; the first beat of the next frame is accepted earliest one cycle after the transfer.
- Latency: out_valid asserts on the clock edge that accepts the in_last beat (visible the following cycle). A 1-word frame therefore gives out_valid one cycle after acceptance.
- Compare: SIGNED=0 uses unsigned magnitude; SIGNED=1 treats words as two's complement (e.g. 8'h80 = -128 is the minimum).
- Outputs are registered only; no combinational path from in_* to out_*. in_ready depends on state only.
- out_* registers hold the last result after returning to IDLE until the next DONE; out_valid alone qualifies them.
- rst asserted mid-frame or in DONE aborts immediately to the reset values; the partial frame is discarded.
- in_data/in_last are ignored when in_valid=0 or in_ready=0.

Test Plan:
1. SIGNED=0, frame 7,2,9,4(last), out_ready=1 -> out_max=9, out_min=2, out_max_idx=2, out_count=4, out_ovf=0; out_valid high exactly 1 cycle.
2. Single word 8'hA5 with in_last=1 -> out_max=out_min=8'hA5, idx=0, count=1; out_valid one cycle after acceptance.
3. Ties plus backpressure: frame 5,9,9,1(last), out_ready=0 for 5 cycles then 1 -> idx=1, min=1; outputs stable and in_ready=0 throughout the hold; returns to IDLE after the transfer.
4. SIGNED=1, frame 8'h7F, 8'h80, 8'h00(last) -> out_max=8'h7F (idx 0), out_min=8'h80; the same frame with SIGNED=0 gives max=8'h80 (idx 1), min=8'h00.
5. CNT_W=4, 20-word frame with values 0..19 -> out_count=15, out_ovf=1, out_max=19 truncated to WIDTH, idx=15 (saturated).
6. Gaps in in_valid mid-frame leave the result unchanged. Assert rst mid-frame after 3 beats -> all outputs 0 immediately; a following frame 3,1(last) gives max=3, min=1, count=2.

Source files
------------

// File: rtl/max_min_stream.sv
// -----------------------------------------------------------------------------
// max_min_stream
//
// Streaming frame statistics. Words arrive one per clock over a valid/ready
// handshake; when the word flagged with in_last is taken, the frame maximum,
// minimum, index of the first maximum, word count and an overflow flag are
// presented over a valid/ready output handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     in_data / in_last valid
//   in_ready     block can accept a word (state only; low while rst is high)
//   in_data      data word, WIDTH bits
//   in_last      marks the final word of a frame
//   out_valid    result registers valid
//   out_ready    consumer accepts the result
//   out_max      frame maximum
//   out_min      frame minimum
//   out_max_idx  0-based index of the first occurrence of the maximum (saturating)
//   out_count    number of words in the frame (saturating at 2^CNT_W-1)
//   out_ovf      frame length exceeded 2^CNT_W-1
//
// Parameters
//   WIDTH   data word width
//   CNT_W   width of the word counter and index outputs
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
// -----------------------------------------------------------------------------
module max_min_stream #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Strictly-greater compare honouring the SIGNED parameter.
    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    state_t             state_q, state_d;

    // Running accumulator for the frame in progress.
    logic [WIDTH-1:0]   acc_max_q, acc_max_d;
    logic [WIDTH-1:0]   acc_min_q, acc_min_d;
    logic [CNT_W-1:0]   acc_idx_q, acc_idx_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               acc_ovf_q, acc_ovf_d;

    // Published result; kept separate from the accumulator so the previous
    // result stays visible while the next frame is being collected.
    logic [WIDTH-1:0]   res_max_q, res_max_d;
    logic [WIDTH-1:0]   res_min_q, res_min_d;
    logic [CNT_W-1:0]   res_idx_q, res_idx_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_ovf_q, res_ovf_d;

    logic               beat;

    assign beat = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_max_q <= '0;
            acc_min_q <= '0;
            acc_idx_q <= '0;
            acc_cnt_q <= '0;
            acc_ovf_q <= 1'b0;
            res_max_q <= '0;
            res_min_q <= '0;
            res_idx_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_max_q <= acc_max_d;
            acc_min_q <= acc_min_d;
            acc_idx_q <= acc_idx_d;
            acc_cnt_q <= acc_cnt_d;
            acc_ovf_q <= acc_ovf_d;
            res_max_q <= res_max_d;
            res_min_q <= res_min_d;
            res_idx_q <= res_idx_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d = in_last ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (beat && in_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: handshake signals are decoded from the state register
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE, S_ACC: in_ready  = ~rst;
            S_DONE:        out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator update
    // -------------------------------------------------------------------------
    always_comb begin
        acc_max_d = acc_max_q;
        acc_min_d = acc_min_q;
        acc_idx_d = acc_idx_q;
        acc_cnt_d = acc_cnt_q;
        acc_ovf_d = acc_ovf_q;
        if (beat) begin
            if (state_q == S_IDLE) begin
                acc_max_d = in_data;
                acc_min_d = in_data;
                acc_idx_d = '0;
                acc_cnt_d = CNT_ONE;
                acc_ovf_d = 1'b0;
            end else begin
                // acc_cnt_q never exceeds CNT_MAX, so the index saturates
                // along with the counter. Ties keep the earlier index.
                if (gt(in_data, acc_max_q)) begin
                    acc_max_d = in_data;
                    acc_idx_d = acc_cnt_q;
                end
                if (gt(acc_min_q, in_data)) begin
                    acc_min_d = in_data;
                end
                if (acc_cnt_q == CNT_MAX) begin
                    acc_ovf_d = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result capture on the final beat of a frame
    // -------------------------------------------------------------------------
    always_comb begin
        res_max_d = res_max_q;
        res_min_d = res_min_q;
        res_idx_d = res_idx_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        if (beat && in_last) begin
            res_max_d = acc_max_d;
            res_min_d = acc_min_d;
            res_idx_d = acc_idx_d;
            res_cnt_d = acc_cnt_d;
            res_ovf_d = acc_ovf_d;
        end
    end

    assign out_max     = res_max_q;
    assign out_min     = res_min_q;
    assign out_max_idx = res_idx_q;
    assign out_count   = res_cnt_q;
    assign out_ovf     = res_ovf_q;

endmodule

// File: tb/tb_max_min_stream.sv
// -----------------------------------------------------------------------------
// Bench for max_min_stream. Three instances share one input stream and one
// out_ready: unsigned/CNT_W=8, signed/CNT_W=8 and unsigned/CNT_W=4.
// -----------------------------------------------------------------------------
module tb_max_min_stream;

    typedef logic [7:0] frame_t[$];
    typedef struct packed {
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] idx;
        logic [7:0] cnt;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       ir0, ir1, ir2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
    logic [7:0] mx0, mx1, mx2, mn0, mn1, mn2, ix0, ix1, cn0, cn1;
    logic [3:0] ix2, cn2;

    logic       ir[3], ov[3], oovf[3];
    logic [7:0] omax[3], omin[3], oidx[3], ocnt[3];

    int total = 0;
    int bad   = 0;

    exp_t sb[3][$];
    int   hold_cyc = 0;
    bit   rnd_bp = 1'b0;
    int   vcnt = 0;

    always #5 clk = ~clk;

    max_min_stream #(.WIDTH(8), .CNT_W(8), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_max(mx0),
        .out_min(mn0), .out_max_idx(ix0), .out_count(cn0), .out_ovf(ovf0));

    max_min_stream #(.WIDTH(8), .CNT_W(8), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_max(mx1),
        .out_min(mn1), .out_max_idx(ix1), .out_count(cn1), .out_ovf(ovf1));

    max_min_stream #(.WIDTH(8), .CNT_W(4), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_max(mx2),
        .out_min(mn2), .out_max_idx(ix2), .out_count(cn2), .out_ovf(ovf2));

    always_comb begin
        ir[0] = ir0;  ir[1] = ir1;  ir[2] = ir2;
        ov[0] = ov0;  ov[1] = ov1;  ov[2] = ov2;
        oovf[0] = ovf0; oovf[1] = ovf1; oovf[2] = ovf2;
        omax[0] = mx0; omax[1] = mx1; omax[2] = mx2;
        omin[0] = mn0; omin[1] = mn1; omin[2] = mn2;
        oidx[0] = ix0; oidx[1] = ix1; oidx[2] = {4'h0, ix2};
        ocnt[0] = cn0; ocnt[1] = cn1; ocnt[2] = {4'h0, cn2};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: frame statistics from the whole list of words.
    function automatic int key(input logic [7:0] w, input bit sgn);
        return sgn ? int'($signed(w)) : int'(w);
    endfunction

    function automatic exp_t model(input frame_t fr, input bit sgn, input int cw);
        exp_t e;
        int   sat = (1 << cw) - 1;
        int   bi = 0;
        int   si = 0;
        for (int i = 1; i < fr.size(); i++) begin
            if (key(fr[i], sgn) > key(fr[bi], sgn)) bi = i;
            if (key(fr[i], sgn) < key(fr[si], sgn)) si = i;
        end
        e.mx  = fr[bi];
        e.mn  = fr[si];
        e.idx = 8'((bi > sat) ? sat : bi);
        e.cnt = 8'((fr.size() > sat) ? sat : fr.size());
        e.ovf = (fr.size() > sat);
        return e;
    endfunction

    // Consumer: either random backpressure or hold_cyc cycles of stall.
    always @(posedge clk) begin
        #1;
        if (!ov[0]) vcnt = 0;
        else        vcnt++;
        out_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : (vcnt > hold_cyc);
    end

    // Monitor / scoreboard
    logic pv[3];
    logic pxfer[3];
    exp_t held[3];
    logic pacc_last = 1'b0;

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                pv[k] = 1'b0;
                pxfer[k] = 1'b0;
                held[k] = '0;
            end
            pacc_last = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                cur = '{omax[k], omin[k], oidx[k], ocnt[k], oovf[k]};
                if (pxfer[k]) begin
                    chk($sformatf("valid_drop%0d", k), 64'(ov[k]), 64'd0);
                    chk($sformatf("idle_hold%0d", k), 64'(cur), 64'(held[k]));
                end else if (ov[k] && !pv[k]) begin
                    chk($sformatf("latency%0d", k), 64'(pacc_last), 64'd1);
                    if (sb[k].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", k), 64'd1, 64'd0);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("max%0d", k), 64'(omax[k]), 64'(e.mx));
                        chk($sformatf("min%0d", k), 64'(omin[k]), 64'(e.mn));
                        chk($sformatf("idx%0d", k), 64'(oidx[k]), 64'(e.idx));
                        chk($sformatf("count%0d", k), 64'(ocnt[k]), 64'(e.cnt));
                        chk($sformatf("ovf%0d", k), 64'(oovf[k]), 64'(e.ovf));
                    end
                    held[k] = cur;
                end else if (ov[k]) begin
                    chk($sformatf("hold_stable%0d", k), 64'(cur), 64'(held[k]));
                    chk($sformatf("ready_in_done%0d", k), 64'(ir[k]), 64'd0);
                end else begin
                    chk($sformatf("idle_hold%0d", k), 64'(cur), 64'(held[k]));
                end
                pv[k] = ov[k];
                pxfer[k] = ov[k] && out_ready;
            end
            pacc_last = in_valid && ir[0] && in_last;
        end
    end

    // Stimulus: every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ir[0]) begin
            tick();
            n++;
            if (n > 500) begin
                chk("ready_timeout", 64'd0, 64'd1);
                $fatal(1, "stalled waiting for in_ready");
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_frame(input frame_t fr, input int gap_pct);
        for (int i = 0; i < fr.size(); i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) tick();
            end
            send_beat(fr[i], (i == fr.size() - 1));
        end
        sb[0].push_back(model(fr, 1'b0, 8));
        sb[1].push_back(model(fr, 1'b1, 8));
        sb[2].push_back(model(fr, 1'b0, 4));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0 || ov[0])
               && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_values();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), 64'(ir[k]), 64'd0);
            chk($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_outs%0d", k),
                64'({omax[k], omin[k], oidx[k], ocnt[k], oovf[k]}), 64'd0);
        end
    endtask

    initial begin
        frame_t fr;
        int     len;
        logic [7:0] corner[4];
        corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h80; corner[3] = 8'h7F;

        #1;
        chk_reset_values();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(ir[0]), 64'd1);
        tick();

        // Basic frame with immediate acceptance of the result.
        fr = {8'd7, 8'd2, 8'd9, 8'd4};
        send_frame(fr, 0);
        drain();

        // Single-word frame.
        fr = {8'hA5};
        send_frame(fr, 0);
        drain();

        // Ties on the maximum with a stalled consumer.
        hold_cyc = 5;
        fr = {8'd5, 8'd9, 8'd9, 8'd1};
        send_frame(fr, 0);
        drain();
        hold_cyc = 0;

        // Signed versus unsigned ordering.
        fr = {8'h7F, 8'h80, 8'h00};
        send_frame(fr, 0);
        drain();

        // Counter saturation on the narrow-counter instance.
        fr = {};
        for (int i = 0; i < 20; i++) fr.push_back(8'(i));
        send_frame(fr, 0);
        drain();

        // Bubbles between beats.
        fr = {8'd40, 8'd3, 8'd200, 8'd17, 8'd200, 8'd9};
        send_frame(fr, 100);
        drain();

        // Abort a frame after three beats.
        send_beat(8'd250, 1'b0);
        send_beat(8'd1, 1'b0);
        send_beat(8'd77, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_values();
        tick();
        rst = 1'b0;
        tick();
        fr = {8'd3, 8'd1};
        send_frame(fr, 0);
        drain();

        // Randomised frames with bubbles and random backpressure.
        rnd_bp = 1'b1;
        for (int f = 0; f < 150; f++) begin
            fr = {};
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) fr.push_back(corner[$urandom_range(0, 3)]);
                else                           fr.push_back(8'($urandom));
            end
            send_frame(fr, 30);
        end
        drain();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
